srl_frame_deser: RTL and testbench
==================================

SRL_FRAME_DESER -- requirements
Module: srl_frame_deser

Interface
REQ-001 Parameter W, default 8: word width in bits; legal range 4..16.
REQ-002 Parameter SYNC, default 8'hA5: sync word, W bits wide.
REQ-003 Parameter FRAME_LEN, default 4: number of payload words after each sync word; legal range 1..15.
REQ-004 Parameter MISS_MAX, default 3: consecutive bad sync slots that cause loss of lock; legal range 1..7.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 i  input  1  serial bit from the upstream delay-line stage.
REQ-008 i_en  input  1  i is valid this cycle; bit accepted only when high.
REQ-009 data  output  W  last completed payload word, MSB first as received.
REQ-010 valid  output  1  one-cycle strobe; data holds a new payload word.
REQ-011 sof  output  1  high with valid on the first payload word of a frame.
REQ-012 locked  output  1  high while in state LOCK.
REQ-013 err_cnt  output  8  sync-miss counter (see Configuration).

Function
REQ-014 Shift register sr (W bits) SHALL update sr <= {sr[W-2:0], i} on each accepted bit; no reset on sr, no other taps (keeps it SRL-inferable).
REQ-015 FSM states SHALL be HUNT and LOCK only.
REQ-016 HUNT: after each accepted bit, if the updated sr equals SYNC, SHALL go to LOCK next cycle with bitcnt=0, wordcnt=1, misses=0.
REQ-017 LOCK: bitcnt SHALL count accepted bits 0..W-1 and wrap; on the W-th bit a word completes and wordcnt advances modulo FRAME_LEN+1.
REQ-018 Word at wordcnt 1..FRAME_LEN is payload: data <= completed word, valid=1 on the next cycle only, sof=1 when wordcnt==1.
REQ-019 Word at wordcnt 0 is the sync slot, never output: equal to SYNC clears misses; unequal increments misses.
REQ-020 When misses reaches MISS_MAX, SHALL return to HUNT next cycle; valid stays low; data holds.
REQ-021 In LOCK, a SYNC pattern in sr at a non-slot position SHALL be ignored.
REQ-022 i_en low SHALL freeze sr, bitcnt, wordcnt and the FSM; valid SHALL be low that cycle.
REQ-023 Latency: valid SHALL rise exactly one clock after the cycle that accepts the last bit of a payload word.
REQ-024 locked SHALL be registered: high from the cycle after the HUNT->LOCK decision through the cycle of the LOCK->HUNT decision.

Reset
REQ-025 rst high SHALL force state HUNT, bitcnt=0, wordcnt=0, misses=0, data=0, valid=0, sof=0, locked=0, err_cnt=0 on the next edge.
REQ-026 rst SHALL take priority over i_en and over any word completing in the same cycle; a partial word in progress is discarded.
REQ-027 After rst deasserts, the first W accepted bits SHALL be needed before any sync match can occur (match logic gated by a fill counter).

Configuration
REQ-028 Macro DESER_ERRCNT_EN defined: err_cnt SHALL increment on every bad sync slot in LOCK, saturate at 8'hFF, and clear only on rst.
REQ-029 Macro DESER_ERRCNT_EN undefined: err_cnt SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-030 Reset then i_en=1, bits A5,11,22,33,44 MSB-first -> locked high after the 8th bit; valid pulses 4 times with data 11,22,33,44; sof only with 11.
REQ-031 Continue with sync A5 then 55,66,77,88 -> 4 more valid pulses, misses stay 0, err_cnt=0.
REQ-032 Locked, feed sync slot 00 three times (frames otherwise good) -> locked drops after 3rd bad slot; err_cnt=3 with DESER_ERRCNT_EN, 0 without.
REQ-033 Toggle i_en low for 1-5 cycles between every bit of the REQ-030 stream -> identical data/sof sequence, valid never high while i_en was low the previous bit slot.
REQ-034 Locked, payload word A5 -> output as data=A5, no realignment.
REQ-035 Assert rst during the 5th bit of a payload word -> all outputs 0 next cycle; relock needs a fresh full A5.

Source files
------------

// File: rtl/srl_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module   : srl_frame_deser
//  Purpose  : Serial-to-parallel frame deserializer. Bits enter a W-bit shift
//             register (kept free of reset and side taps so it maps onto an
//             SRL primitive). A HUNT/LOCK state machine finds the sync word and
//             then walks fixed-length frames: one sync slot followed by
//             FRAME_LEN payload words. Payload words are presented on data with
//             a one-cycle valid strobe. sof marks the first payload word of a
//             frame. MISS_MAX consecutive bad sync slots drop the lock.
//  Ports    : clk     - single clock, rising edge
//             rst     - synchronous, active-high reset
//             i       - serial input bit
//             i_en    - i is valid this cycle
//             data    - last completed payload word, MSB first as received
//             valid   - one-cycle strobe for a new payload word
//             sof     - with valid, first payload word of a frame
//             locked  - high while in LOCK (registered)
//             err_cnt - saturating bad-sync-slot counter
//  Options  : DESER_ERRCNT_EN - when defined, err_cnt counts bad sync slots.
//             When it is undefined, err_cnt is tied to zero and has no flops.
//  Revision : 1.0 - initial release
// ============================================================================
module srl_frame_deser #(
  parameter int unsigned  W         = 8,
  parameter logic [W-1:0] SYNC      = 8'hA5,
  parameter int unsigned  FRAME_LEN = 4,
  parameter int unsigned  MISS_MAX  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i,
  input  logic         i_en,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         sof,
  output logic         locked,
  output logic [7:0]   err_cnt
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t       state;
  logic [W-1:0] sr;
  logic [W-1:0] sr_next;
  logic [3:0]   bitcnt;
  logic [3:0]   wordcnt;
  logic [2:0]   misses;
  logic [4:0]   fill;

  logic         sync_hit;
  logic         fill_ok;
  logic         word_done;
  logic         at_slot;
  logic         slot_bad;
  logic         lose_lock;
  logic         unused_sr_msb;

  // The oldest bit only ever falls off the end of the shift register.
  assign unused_sr_msb = sr[W-1];

  // All decisions look at the register as it will be after this bit.
  assign sr_next   = {sr[W-2:0], i};
  assign sync_hit  = (sr_next == SYNC);
  // The register holds stale bits after reset; a match only counts once it
  // has been filled with W freshly accepted bits.
  assign fill_ok   = (fill >= 5'(W - 1));
  assign word_done = (bitcnt == 4'(W - 1));
  assign at_slot   = (wordcnt == 4'd0);
  assign slot_bad  = i_en && (state == LOCK) && word_done && at_slot && !sync_hit;
  assign lose_lock = slot_bad && ((misses + 3'd1) >= 3'(MISS_MAX));

  // Plain enable-only shift register: no reset, no parallel taps besides the
  // comparison of its next value.
  always_ff @(posedge clk) begin
    if (i_en) begin
      sr <= sr_next;
    end
  end

  // Counts accepted bits since reset, saturating at W.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= '0;
    end else if (i_en && (fill != 5'(W))) begin
      fill <= fill + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HUNT;
      bitcnt  <= '0;
      wordcnt <= '0;
      misses  <= '0;
      data    <= '0;
      valid   <= 1'b0;
      sof     <= 1'b0;
      locked  <= 1'b0;
    end else begin
      valid <= 1'b0;
      sof   <= 1'b0;
      if (i_en) begin
        case (state)
          HUNT: begin
            if (sync_hit && fill_ok) begin
              state   <= LOCK;
              bitcnt  <= '0;
              wordcnt <= 4'd1;
              misses  <= '0;
              locked  <= 1'b1;
            end
          end
          LOCK: begin
            if (!word_done) begin
              bitcnt <= bitcnt + 4'd1;
            end else begin
              bitcnt  <= '0;
              wordcnt <= (wordcnt == 4'(FRAME_LEN)) ? 4'd0 : wordcnt + 4'd1;
              if (!at_slot) begin
                // Payload word; a sync-looking payload is passed through as data.
                data  <= sr_next;
                valid <= 1'b1;
                sof   <= (wordcnt == 4'd1);
              end else if (sync_hit) begin
                misses <= '0;
              end else if (lose_lock) begin
                state   <= HUNT;
                locked  <= 1'b0;
                misses  <= '0;
                wordcnt <= '0;
              end else begin
                misses <= misses + 3'd1;
              end
            end
          end
          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

`ifdef DESER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'h00;
    end else if (slot_bad && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_srl_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srl_frame_deser
//  Purpose  : Self-checking bench for srl_frame_deser (W=8, SYNC=A5,
//             FRAME_LEN=4, MISS_MAX=3). Words from a table are shifted in MSB
//             first; after the last bit of each word the outputs are compared
//             with hand-computed values. Hand-written sequences cover i_en
//             gaps and reset in the middle of a payload word.
//  Ports    : none
//  Options  : DESER_ERRCNT_EN - selects the expected err_cnt values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_srl_frame_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i = 1'b0;
  logic       i_en = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       sof;
  logic       locked;
  logic [7:0] err_cnt;

  srl_frame_deser #(
    .W(8), .SYNC(8'hA5), .FRAME_LEN(4), .MISS_MAX(3)
  ) dut (
    .clk(clk), .rst(rst), .i(i), .i_en(i_en),
    .data(data), .valid(valid), .sof(sof), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  typedef struct {
    logic [7:0] word;
    logic       ev;   // expected valid
    logic [7:0] ed;   // expected data
    logic       es;   // expected sof
    logic       el;   // expected locked
    logic [7:0] ee;   // bad sync slots so far
  } vec_t;

  vec_t tbl[30];

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_err(logic [7:0] m);
`ifdef DESER_ERRCNT_EN
    return m;
`else
    return (m & 8'h00);
`endif
  endfunction

  // Every valid pulse must come from an edge that accepted a bit.
  always @(posedge clk) begin
    logic en_at_edge;
    en_at_edge = i_en;
    #1;
    if (valid) begin
      pulses++;
      chk("valid_without_accept", {7'd0, en_at_edge}, 8'h01);
    end
  end

  task automatic drive_bit(logic b, int gap_max);
    if (gap_max > 0) begin
      int n;
      n = $urandom_range(gap_max, 1);
      for (int g = 0; g < n; g++) begin
        @(negedge clk);
        i_en = 1'b0;
        i    = 1'($urandom);
      end
    end
    @(negedge clk);
    i    = b;
    i_en = 1'b1;
  endtask

  // Returns 1 time unit after the edge that accepted the last bit.
  task automatic send_word(logic [7:0] w, int gap_max);
    for (int b = 7; b >= 0; b--) begin
      drive_bit(w[b], gap_max);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(int first, int last, int gap_max);
    for (int k = first; k <= last; k++) begin
      send_word(tbl[k].word, gap_max);
      chk($sformatf("w%0d_valid", k),  {7'd0, valid},  {7'd0, tbl[k].ev});
      chk($sformatf("w%0d_data", k),   data,           tbl[k].ed);
      chk($sformatf("w%0d_sof", k),    {7'd0, sof},    {7'd0, tbl[k].es});
      chk($sformatf("w%0d_locked", k), {7'd0, locked}, {7'd0, tbl[k].el});
      chk($sformatf("w%0d_errcnt", k), err_cnt,        exp_err(tbl[k].ee));
    end
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_data"},   data,            8'h00);
    chk({tag, "_valid"},  {7'd0, valid},   8'h00);
    chk({tag, "_sof"},    {7'd0, sof},     8'h00);
    chk({tag, "_locked"}, {7'd0, locked},  8'h00);
    chk({tag, "_errcnt"}, err_cnt,         8'h00);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst  = 1'b1;
    i_en = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // word, valid, data, sof, locked, bad slots
    tbl[0]  = '{8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    tbl[1]  = '{8'h11, 1'b1, 8'h11, 1'b1, 1'b1, 8'd0};
    tbl[2]  = '{8'h22, 1'b1, 8'h22, 1'b0, 1'b1, 8'd0};
    tbl[3]  = '{8'h33, 1'b1, 8'h33, 1'b0, 1'b1, 8'd0};
    tbl[4]  = '{8'h44, 1'b1, 8'h44, 1'b0, 1'b1, 8'd0};
    tbl[5]  = '{8'hA5, 1'b0, 8'h44, 1'b0, 1'b1, 8'd0};
    tbl[6]  = '{8'h55, 1'b1, 8'h55, 1'b1, 1'b1, 8'd0};
    tbl[7]  = '{8'h66, 1'b1, 8'h66, 1'b0, 1'b1, 8'd0};
    tbl[8]  = '{8'hA5, 1'b1, 8'hA5, 1'b0, 1'b1, 8'd0};
    tbl[9]  = '{8'h88, 1'b1, 8'h88, 1'b0, 1'b1, 8'd0};
    tbl[10] = '{8'hA5, 1'b0, 8'h88, 1'b0, 1'b1, 8'd0};
    tbl[11] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b1, 8'd0};
    tbl[12] = '{8'h02, 1'b1, 8'h02, 1'b0, 1'b1, 8'd0};
    tbl[13] = '{8'h03, 1'b1, 8'h03, 1'b0, 1'b1, 8'd0};
    tbl[14] = '{8'h04, 1'b1, 8'h04, 1'b0, 1'b1, 8'd0};
    tbl[15] = '{8'h00, 1'b0, 8'h04, 1'b0, 1'b1, 8'd1};
    tbl[16] = '{8'h05, 1'b1, 8'h05, 1'b1, 1'b1, 8'd1};
    tbl[17] = '{8'h06, 1'b1, 8'h06, 1'b0, 1'b1, 8'd1};
    tbl[18] = '{8'h07, 1'b1, 8'h07, 1'b0, 1'b1, 8'd1};
    tbl[19] = '{8'h08, 1'b1, 8'h08, 1'b0, 1'b1, 8'd1};
    tbl[20] = '{8'h00, 1'b0, 8'h08, 1'b0, 1'b1, 8'd2};
    tbl[21] = '{8'h09, 1'b1, 8'h09, 1'b1, 1'b1, 8'd2};
    tbl[22] = '{8'h0A, 1'b1, 8'h0A, 1'b0, 1'b1, 8'd2};
    tbl[23] = '{8'h0B, 1'b1, 8'h0B, 1'b0, 1'b1, 8'd2};
    tbl[24] = '{8'h0C, 1'b1, 8'h0C, 1'b0, 1'b1, 8'd2};
    tbl[25] = '{8'h00, 1'b0, 8'h0C, 1'b0, 1'b0, 8'd3};
    tbl[26] = '{8'hA5, 1'b0, 8'h0C, 1'b0, 1'b1, 8'd3};
    tbl[27] = '{8'h11, 1'b1, 8'h11, 1'b1, 1'b1, 8'd3};
    // relock after a mid-word reset
    tbl[28] = '{8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    tbl[29] = '{8'h22, 1'b1, 8'h22, 1'b1, 1'b1, 8'd0};

    // Phase 1: lock, two good frames, payload A5, three bad slots, relock.
    apply_reset();
    pulses = 0;
    run_table(0, 27, 0);
    chk("phase1_pulses", 8'(pulses), 8'd21);

    // Phase 2: same opening stream with 1..5 idle cycles before every bit.
    apply_reset();
    pulses = 0;
    run_table(0, 4, 5);
    chk("phase2_pulses", 8'(pulses), 8'd4);

    // Phase 3: reset on the 5th bit of a payload word. The bits around the
    // reset line up into A5 in the shift register; that must not lock.
    run_table(5, 6, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    @(negedge clk);
    i    = 1'b0;
    i_en = 1'b1;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midword_rst");
    @(negedge clk);
    rst = 1'b0;
    i_en = 1'b0;
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    @(posedge clk);
    #1;
    chk("no_false_lock", {7'd0, locked}, 8'h00);
    chk("no_false_valid", {7'd0, valid}, 8'h00);
    run_table(28, 29, 0);

    @(negedge clk);
    i_en = 1'b0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
